// File: rtl/gcd_arbiter.sv
// gcd_arbiter: round-robin front end that shares one level-handshake gcd core between NREQ requesters.
// Optional watchdog abort is compiled in when GCD_ARB_TIMEOUT_EN is defined.
module gcd_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*W-1:0]       req_opa,
    input  logic [NREQ*W-1:0]       req_opb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [W-1:0]            rsp_result,
    output logic                    rsp_err,
    output logic [W-1:0]            core_opa,
    output logic [W-1:0]            core_opb,
    output logic                    core_start,
    input  logic [W-1:0]            core_result,
    input  logic                    core_done
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, RUN, RESP, DRAIN} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [W-1:0]   opa_q, opa_d;
    logic [W-1:0]   opb_q, opb_d;
    logic [W-1:0]   result_q, result_d;
    logic           zero_q, zero_d;
    logic           seen_low_q, seen_low_d;

    logic           grant_any;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] scan_idx;
    logic [W-1:0]   sel_opa, sel_opb;

`ifdef GCD_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           err_q, err_d;
`else
    logic           timeout_unused;
    assign timeout_unused = (TIMEOUT == 0);
`endif

    // Rotating-priority search: first valid requester at or above ptr, wrapping around.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = IDW'((int'(ptr_q) + k) % NREQ);
            if (!grant_any && req_valid[scan_idx]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    always_comb begin
        sel_opa = '0;
        sel_opb = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_idx == IDW'(k)) begin
                sel_opa = req_opa[k*W +: W];
                sel_opb = req_opb[k*W +: W];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (resetn && state_q == IDLE && grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        result_d   = result_q;
        zero_d     = zero_q;
        seen_low_d = seen_low_q;
`ifdef GCD_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    id_d       = grant_idx;
                    ptr_d      = IDW'((int'(grant_idx) + 1) % NREQ);
                    opa_d      = sel_opa;
                    opb_d      = sel_opb;
                    seen_low_d = 1'b0;
`ifdef GCD_ARB_TIMEOUT_EN
                    cnt_d      = '0;
                    err_d      = 1'b0;
`endif
                    if (sel_opa == '0 || sel_opb == '0) begin
                        result_d = sel_opa | sel_opb;
                        zero_d   = 1'b1;
                        state_d  = RESP;
                    end else begin
                        zero_d   = 1'b0;
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                // A done that was already high on entry is stale until it has been seen low.
                if (!core_done) begin
                    seen_low_d = 1'b1;
                end
`ifdef GCD_ARB_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
                if (core_done && seen_low_q) begin
                    result_d = core_result;
                    state_d  = RESP;
                end
`ifdef GCD_ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = RESP;
                end
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = zero_q ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                if (!core_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            id_q       <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            seen_low_q <= 1'b0;
`ifdef GCD_ARB_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            seen_low_q <= seen_low_d;
`ifdef GCD_ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    assign core_start = (state_q == RUN);
    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = id_q;
    assign rsp_result = result_q;
    assign core_opa   = opa_q;
    assign core_opb   = opb_q;
`ifdef GCD_ARB_TIMEOUT_EN
    assign rsp_err    = err_q;
`else
    assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_arbiter.sv
// Self-checking bench for gcd_arbiter: behavioural core model, round-robin reference model and
// per-cycle compare, plus directed cases with hand-computed results.
module tb_gcd_arbiter;
    localparam int NREQ    = 4;
    localparam int W       = 32;
    localparam int TIMEOUT = 16;
    localparam int IDW     = 2;

    logic                  clk = 1'b0;
    logic                  resetn;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*W-1:0]     req_opa;
    logic [NREQ*W-1:0]     req_opb;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [W-1:0]          rsp_result;
    logic                  rsp_err;
    logic [W-1:0]          core_opa;
    logic [W-1:0]          core_opb;
    logic                  core_start;
    logic [W-1:0]          core_result;
    logic                  core_done;

    always #5 clk = ~clk;

    gcd_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opa(req_opa), .req_opb(req_opb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_err(rsp_err),
        .core_opa(core_opa), .core_opb(core_opb), .core_start(core_start),
        .core_result(core_result), .core_done(core_done)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model state: what the arbiter must be doing, in terms of jobs rather than states.
    int         m_ptr;
    bit         m_busy, m_running, m_rsp, m_zero, m_drain, m_seen_low;
    int         m_runcyc;
    int         m_id;
    logic [W-1:0] m_a, m_b, m_res;
    logic       m_err;

    int         cyc, grant_cyc, last_lat;
    bit         lat_pending;
    bit         start_seen;
    int         pulses0;

    int           log_id[$];
    logic [W-1:0] log_res[$];
    logic         log_err[$];

    // Core model and stimulus state.
    bit           c_busy, c_sig, c_hang;
    int           c_lat, c_drop;
    logic [W-1:0] c_a, c_b;
    logic         s_start;
    logic [W-1:0] s_opa, s_opb;
    logic [NREQ-1:0] s_grant;
    bit           rnd;

    function automatic logic [W-1:0] gcdRef(input logic [W-1:0] a_in, input logic [W-1:0] b_in);
        logic [W-1:0] a, b, t;
        a = a_in;
        b = b_in;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expectRsp(input string name, input int id, input logic [W-1:0] res, input logic err);
        if (log_id.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL %s: got no response, expected id %0d result %0d", name, id, res);
        end else begin
            checkOutput({name, "_id"}, log_id.pop_front(), id);
            checkOutput({name, "_result"}, log_res.pop_front(), res);
            checkOutput({name, "_err"}, log_err.pop_front(), err);
        end
    endtask

    // Per-cycle compare, sampled at the falling edge, then advance the model by one clock edge.
    task automatic monitor();
        logic [NREQ-1:0] exp_ready;
        int g;
        bit found;
        cyc++;
        s_start = core_start;
        s_opa   = core_opa;
        s_opb   = core_opb;
        s_grant = req_ready;
        if (core_start) start_seen = 1;
        if (req_ready[0]) pulses0++;
        if (!resetn) begin
            checkOutput("reset_ctrl", {req_ready, rsp_valid, core_start, rsp_id, rsp_err}, 0);
            checkOutput("reset_result", rsp_result, 0);
            checkOutput("reset_core_ops", {core_opa, core_opb}, 0);
            m_ptr = 0; m_busy = 0; m_running = 0; m_rsp = 0; m_drain = 0; lat_pending = 0;
            return;
        end
        exp_ready = '0;
        found = 0;
        g = 0;
        if (!m_busy) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!found && req_valid[(m_ptr + k) % NREQ]) begin
                    found = 1;
                    g = (m_ptr + k) % NREQ;
                    exp_ready[g] = 1'b1;
                end
            end
        end
        checkOutput("req_ready", req_ready, exp_ready);
        checkOutput("core_start", core_start, m_running);
        checkOutput("rsp_valid", rsp_valid, m_rsp);
        if (m_running) begin
            checkOutput("core_opa", core_opa, m_a);
            checkOutput("core_opb", core_opb, m_b);
        end
        if (m_rsp && rsp_valid) begin
            checkOutput("rsp_id", rsp_id, m_id);
            checkOutput("rsp_result", rsp_result, m_res);
            checkOutput("rsp_err", rsp_err, m_err);
            if (lat_pending) begin
                last_lat = cyc - grant_cyc;
                lat_pending = 0;
            end
        end
        if (m_drain && !core_done) begin
            m_drain = 0;
            m_busy = 0;
        end
        if (m_rsp && rsp_ready) begin
            m_rsp = 0;
            log_id.push_back(m_id);
            log_res.push_back(m_res);
            log_err.push_back(m_err);
            if (m_zero) m_busy = 0;
            else m_drain = 1;
        end
        if (m_running) begin
            m_runcyc++;
            if (core_done && m_seen_low) begin
                m_running = 0; m_rsp = 1; m_res = gcdRef(m_a, m_b); m_err = 0;
            end else begin
                if (!core_done) m_seen_low = 1;
`ifdef GCD_ARB_TIMEOUT_EN
                if (m_runcyc == TIMEOUT) begin
                    m_running = 0; m_rsp = 1; m_res = '0; m_err = 1;
                end
`endif
            end
        end
        if (found) begin
            m_busy = 1;
            m_ptr = (g + 1) % NREQ;
            m_id = g;
            m_a = req_opa[g*W +: W];
            m_b = req_opb[g*W +: W];
            m_zero = (m_a == 0) || (m_b == 0);
            grant_cyc = cyc;
            lat_pending = 1;
            if (m_zero) begin
                m_rsp = 1; m_res = gcdRef(m_a, m_b); m_err = 0;
            end else begin
                m_running = 1; m_seen_low = 0; m_runcyc = 0;
            end
        end
    endtask

    task automatic randOps(output logic [W-1:0] a, output logic [W-1:0] b);
        logic [W-1:0] k;
        case ($urandom_range(0, 7))
            0: begin a = '0; b = $urandom; end
            1: begin a = $urandom; b = '0; end
            2: begin a = '0; b = '0; end
            3: begin a = $urandom_range(1, 500); b = $urandom_range(1, 500); end
            default: begin
                k = $urandom_range(1, 1000);
                a = k * $urandom_range(1, 1000000);
                b = k * $urandom_range(1, 1000000);
            end
        endcase
    endtask

    // Requesters and core model respond just after the rising edge.
    task automatic apply();
        logic [W-1:0] a, b;
        for (int i = 0; i < NREQ; i++) begin
            if (s_grant[i]) req_valid[i] = 1'b0;
        end
        if (s_start) begin
            if (!c_busy) begin
                c_busy = 1; c_sig = 0; c_lat = $urandom_range(1, 8); c_a = s_opa; c_b = s_opb;
            end else if (core_done && !c_sig) begin
                core_done = 1'b0;
            end else if (!core_done && !c_hang) begin
                if (c_lat <= 1) begin
                    core_done = 1'b1; c_sig = 1; core_result = gcdRef(c_a, c_b);
                end else begin
                    c_lat--;
                end
            end
        end else begin
            c_busy = 0;
            c_sig = 0;
            if (core_done) begin
                if (c_drop == 0) begin
                    core_done = 1'b0;
                    c_drop = $urandom_range(0, 2);
                end else begin
                    c_drop--;
                end
            end
        end
        if (rnd) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    randOps(a, b);
                    req_opa[i*W +: W] = a;
                    req_opb[i*W +: W] = b;
                    req_valid[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic stepCycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        apply();
    endtask

    task automatic applyStimulus(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
        req_opa[idx*W +: W] = a;
        req_opb[idx*W +: W] = b;
        req_valid[idx] = 1'b1;
    endtask

    task automatic waitIdle(input int budget, input string name);
        int n;
        n = 0;
        while ((m_busy || req_valid != 0) && n < budget) begin
            stepCycle();
            n++;
        end
        checkOutput({name, "_completion"}, {m_busy, req_valid}, 0);
    endtask

    task automatic doReset(input int cycles);
        resetn = 1'b0;
        #1;
        checkOutput("async_reset_start", core_start, 0);
        checkOutput("async_reset_rsp", {rsp_valid, rsp_result}, 0);
        repeat (cycles) stepCycle();
        resetn = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n, vcount;
        resetn = 1'b0; req_valid = '0; req_opa = '0; req_opb = '0; rsp_ready = 1'b1;
        core_done = 1'b0; core_result = '0;
        rnd = 0; c_busy = 0; c_sig = 0; c_hang = 0; c_lat = 0; c_drop = 0;
        cyc = 0; m_ptr = 0; m_busy = 0; m_running = 0; m_rsp = 0; m_drain = 0;
        repeat (3) stepCycle();
        resetn = 1'b1;

        $display("[TB] single requester");
        checkOutput("model_gcd_102_12", gcdRef(102, 12), 6);
        pulses0 = 0;
        applyStimulus(0, 102, 12);
        waitIdle(200, "t1");
        checkOutput("t1_ready_pulses", pulses0, 1);
        expectRsp("t1", 0, 6, 0);

        $display("[TB] four requesters at once");
        doReset(2);
        applyStimulus(0, 18190, 13082);
        applyStimulus(1, 82066, 36915);
        applyStimulus(2, 34456, 36928);
        applyStimulus(3, 76156, 1924);
        waitIdle(400, "t2");
        expectRsp("t2_r0", 0, 2, 0);
        expectRsp("t2_r1", 1, 1, 0);
        expectRsp("t2_r2", 2, 8, 0);
        expectRsp("t2_r3", 3, 4, 0);
        applyStimulus(1, 68490, 78579);
        waitIdle(200, "t2b");
        expectRsp("t2b", 1, 9, 0);

        $display("[TB] zero operands");
        start_seen = 0;
        applyStimulus(2, 0, 65414);
        waitIdle(50, "t3a");
        checkOutput("t3_zero_latency", last_lat, 1);
        expectRsp("t3a", 2, 65414, 0);
        applyStimulus(3, 0, 0);
        waitIdle(50, "t3b");
        expectRsp("t3b", 3, 0, 0);
        checkOutput("t3_no_core_start", start_seen, 0);

        $display("[TB] response backpressure");
        rsp_ready = 1'b0;
        applyStimulus(0, 10118, 64431);
        n = 0;
        while (!rsp_valid && n < 100) begin
            stepCycle();
            n++;
        end
        checkOutput("t4_rsp_arrives", rsp_valid, 1);
        applyStimulus(2, 7, 21);
        vcount = 0;
        repeat (20) begin
            stepCycle();
            if (rsp_valid) vcount++;
        end
        checkOutput("t4_valid_held", vcount, 20);
        rsp_ready = 1'b1;
        waitIdle(200, "t4");
        expectRsp("t4_r0", 0, 1, 0);
        expectRsp("t4_r2", 2, 7, 0);

        $display("[TB] reset during computation");
        applyStimulus(1, 59203, 36405);
        n = 0;
        while (!core_start && n < 20) begin
            stepCycle();
            n++;
        end
        checkOutput("t5_core_started", core_start, 1);
        stepCycle();
        doReset(4);
        checkOutput("t5_no_rsp", log_id.size(), 0);
        applyStimulus(1, 59203, 36405);
        applyStimulus(3, 4, 6);
        waitIdle(300, "t5");
        expectRsp("t5_r1", 1, 1, 0);
        expectRsp("t5_r3", 3, 2, 0);

`ifdef GCD_ARB_TIMEOUT_EN
        $display("[TB] watchdog abort");
        c_hang = 1;
        applyStimulus(0, 5, 10);
        waitIdle(100, "t6");
        checkOutput("t6_latency", last_lat, 17);
        expectRsp("t6", 0, 0, 1);
        c_hang = 0;
        applyStimulus(0, 9, 6);
        waitIdle(100, "t6b");
        expectRsp("t6b", 0, 3, 0);
`endif

        $display("[TB] randomized traffic");
        rnd = 1;
        repeat (3000) stepCycle();
        rnd = 0;
        rsp_ready = 1'b1;
        waitIdle(2000, "rnd");
        checkOutput("rnd_some_responses", log_id.size() > 50, 1);
        log_id.delete();
        log_res.delete();
        log_err.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
